// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam int DEFAULT_MEM_TIMEOUT = 255;
    localparam int WAIT_CNT_W          = 8;
    localparam int REG_ADDR_W          = 5;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side signals of the controller: hazard inputs from ID/EX/MEM
// and the register enables, flushes and status going back to the datapath.
interface pipeline_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    import pipeline_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0]  ID_Rs;
    logic [REG_ADDR_W-1:0]  ID_Rt;
    logic                   ID_UsesRt;
    logic                   EX_MemRead;
    logic [REG_ADDR_W-1:0]  EX_WriteRegister;
    logic                   EX_BranchTaken;
    logic                   MEM_Req;
    logic                   MEM_Ready;

    logic                   PC_Enable;
    logic                   IF_ID_Enable;
    logic                   ID_EX_Enable;
    logic                   EX_MEM_Enable;
    logic                   MEM_WB_Enable;
    logic                   IF_ID_Flush;
    logic                   ID_EX_Flush;
    logic                   MemError;
    logic [STALL_CNT_W-1:0] StallCount;

    // Datapath side: drives hazard inputs, consumes enables/flushes.
    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_WriteRegister,
               EX_BranchTaken, MEM_Req, MEM_Ready,
        input  PC_Enable, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable,
               MEM_WB_Enable, IF_ID_Flush, ID_EX_Flush, MemError, StallCount
    );

    // Controller side.
    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_WriteRegister,
               EX_BranchTaken, MEM_Req, MEM_Ready,
        output PC_Enable, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable,
               MEM_WB_Enable, IF_ID_Flush, ID_EX_Flush, MemError, StallCount
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use and taken-branch decode.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_write_reg_i,
    input  logic                  ex_branch_taken_i,
    output logic                  load_use_o,
    output logic                  branch_o
);

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    always_comb begin
        load_use_o = ex_mem_read_i
                   && (ex_write_reg_i != '0)
                   && ((ex_write_reg_i == id_rs_i)
                       || (id_uses_rt_i && (ex_write_reg_i == id_rt_i)));
        branch_o   = ex_branch_taken_i;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with memory-wait timeout and stall counter.
//
//   state       | meaning
//   ------------+----------------------------------------------------
//   ST_RUN      | normal issue; hazards handled combinationally
//   ST_MEM_WAIT | data memory busy; wait_q counts consecutive wait cycles
//   ST_ERROR    | memory timed out; pipeline frozen until reset
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int STALL_CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

    state_e                 state_q, state_d;
    logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic mem_wait;
    logic load_use;
    logic branch;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush;

    hazard_detect u_hazard_detect (
        .id_rs_i           (bus.ID_Rs),
        .id_rt_i           (bus.ID_Rt),
        .id_uses_rt_i      (bus.ID_UsesRt),
        .ex_mem_read_i     (bus.EX_MemRead),
        .ex_write_reg_i    (bus.EX_WriteRegister),
        .ex_branch_taken_i (bus.EX_BranchTaken),
        .load_use_o        (load_use),
        .branch_o          (branch)
    );

    assign mem_wait = bus.MEM_Req & ~bus.MEM_Ready;

    // Enables/flushes by priority ERROR > memory wait > branch > load-use;
    // reset forces everything low without waiting for a clock.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!reset || (state_q == ST_ERROR) || mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Next-state and wait-counter logic; wait_q stops at TIMEOUT_CNT so it
    // can never wrap.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_CNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_wait) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else if (wait_q == TIMEOUT_CNT) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_CNT_W'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Stall counter saturates at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign bus.PC_Enable     = pc_en;
    assign bus.IF_ID_Enable  = if_id_en;
    assign bus.ID_EX_Enable  = id_ex_en;
    assign bus.EX_MEM_Enable = ex_mem_en;
    assign bus.MEM_WB_Enable = mem_wb_en;
    assign bus.IF_ID_Flush   = if_id_flush;
    assign bus.ID_EX_Flush   = id_ex_flush;
    assign bus.MemError      = reset && (state_q == ST_ERROR);
    assign bus.StallCount    = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default instance and a short-timeout,
// narrow-counter instance share the same stimulus.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_wr;
    logic       id_uses_rt, ex_mem_read, ex_br, mem_req, mem_ready;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl_if #(.STALL_CNT_W(16)) bus ();
    pipeline_ctrl_if #(.STALL_CNT_W(4))  bus4 ();

    pipeline_ctrl #(.STALL_CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipeline_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    assign bus.ID_Rs             = id_rs;
    assign bus.ID_Rt             = id_rt;
    assign bus.ID_UsesRt         = id_uses_rt;
    assign bus.EX_MemRead        = ex_mem_read;
    assign bus.EX_WriteRegister  = ex_wr;
    assign bus.EX_BranchTaken    = ex_br;
    assign bus.MEM_Req           = mem_req;
    assign bus.MEM_Ready         = mem_ready;
    assign bus4.ID_Rs            = id_rs;
    assign bus4.ID_Rt            = id_rt;
    assign bus4.ID_UsesRt        = id_uses_rt;
    assign bus4.EX_MemRead       = ex_mem_read;
    assign bus4.EX_WriteRegister = ex_wr;
    assign bus4.EX_BranchTaken   = ex_br;
    assign bus4.MEM_Req          = mem_req;
    assign bus4.MEM_Ready        = mem_ready;

    logic [4:0] en, en4;
    logic [1:0] fl, fl4;
    assign en  = {bus.PC_Enable, bus.IF_ID_Enable, bus.ID_EX_Enable,
                  bus.EX_MEM_Enable, bus.MEM_WB_Enable};
    assign fl  = {bus.IF_ID_Flush, bus.ID_EX_Flush};
    assign en4 = {bus4.PC_Enable, bus4.IF_ID_Enable, bus4.ID_EX_Enable,
                  bus4.EX_MEM_Enable, bus4.MEM_WB_Enable};
    assign fl4 = {bus4.IF_ID_Flush, bus4.ID_EX_Flush};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_wr = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_br = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        ex_mem_read = 1'b1; ex_wr = 5'd5; id_rs = 5'd5; ex_br = 1'b1;
        tick(2);
        checks++;
        if (en !== 5'b00000) begin
            errors++; $display("FAIL reset_enables got %b want %b", en, 5'b00000);
        end
        checks++;
        if (fl !== 2'b00) begin
            errors++; $display("FAIL reset_flushes got %b want %b", fl, 2'b00);
        end
        checks++;
        if (bus.StallCount !== 16'd0 || bus.MemError !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got cnt %0d err %b want cnt 0 err 0",
                     bus.StallCount, bus.MemError);
        end
        checks++;
        if (dut.state_q !== ST_RUN || dut.wait_q !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got %0d wait %0d want 0 wait 0",
                     dut.state_q, dut.wait_q);
        end
        idle();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_wr = 5'd5; id_rs = 5'd5;
        #1;
        checks++;
        if (en !== 5'b00111 || fl !== 2'b01) begin
            errors++;
            $display("FAIL lu_rs got en %b fl %b want en 00111 fl 01", en, fl);
        end
        tick(1);
        checks++;
        if (bus.StallCount !== 16'd1) begin
            errors++; $display("FAIL lu_count got %0d want 1", bus.StallCount);
        end
        idle();
        checks++;
        if (en !== 5'b11111 || fl !== 2'b00) begin
            errors++;
            $display("FAIL lu_release got en %b fl %b want en 11111 fl 00", en, fl);
        end
        ex_mem_read = 1'b1; ex_wr = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
        #1;
        checks++;
        if (en !== 5'b00111 || fl !== 2'b01) begin
            errors++;
            $display("FAIL lu_rt got en %b fl %b want en 00111 fl 01", en, fl);
        end
        id_uses_rt = 1'b0;
        #1;
        checks++;
        if (en !== 5'b11111 || fl !== 2'b00) begin
            errors++;
            $display("FAIL lu_rt_unused got en %b fl %b want en 11111 fl 00", en, fl);
        end
        idle();
        ex_mem_read = 1'b1; ex_wr = 5'd0; id_rs = 5'd0;
        #1;
        checks++;
        if (en !== 5'b11111 || fl !== 2'b00) begin
            errors++;
            $display("FAIL lu_r0 got en %b fl %b want en 11111 fl 00", en, fl);
        end
        tick(1);
        checks++;
        if (bus.StallCount !== 16'd1) begin
            errors++; $display("FAIL lu_r0_count got %0d want 1", bus.StallCount);
        end
        idle();
    endtask

    task automatic test_branch_lu();
        ex_mem_read = 1'b1; ex_wr = 5'd9; id_rs = 5'd9; ex_br = 1'b1;
        #1;
        checks++;
        if (en !== 5'b11111 || fl !== 2'b11) begin
            errors++;
            $display("FAIL br_lu got en %b fl %b want en 11111 fl 11", en, fl);
        end
        tick(1);
        checks++;
        if (bus.StallCount !== 16'd1) begin
            errors++; $display("FAIL br_lu_count got %0d want 1", bus.StallCount);
        end
        idle();
    endtask

    task automatic test_mem_wait();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (en !== 5'b00000 || fl !== 2'b00) begin
                errors++;
                $display("FAIL mw_freeze cyc %0d got en %b fl %b want en 00000 fl 00",
                         i, en, fl);
            end
            tick(1);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (en !== 5'b11111) begin
            errors++; $display("FAIL mw_ready got en %b want 11111", en);
        end
        tick(1);
        checks++;
        if (dut.state_q !== ST_RUN || dut.wait_q !== 8'd0 || bus.MemError !== 1'b0) begin
            errors++;
            $display("FAIL mw_exit got st %0d wait %0d err %b want st 0 wait 0 err 0",
                     dut.state_q, dut.wait_q, bus.MemError);
        end
        checks++;
        if (bus.StallCount !== 16'd4) begin
            errors++; $display("FAIL mw_count got %0d want 4", bus.StallCount);
        end
        mem_ready = 1'b0; ex_br = 1'b1;
        #1;
        checks++;
        if (en !== 5'b00000 || fl !== 2'b00) begin
            errors++;
            $display("FAIL mw_over_br got en %b fl %b want en 00000 fl 00", en, fl);
        end
        ex_br = 1'b0;
        tick(1);
        checks++;
        if (dut.state_q !== ST_MEM_WAIT || dut.wait_q !== 8'd1) begin
            errors++;
            $display("FAIL mw_enter got st %0d wait %0d want st 1 wait 1",
                     dut.state_q, dut.wait_q);
        end
        mem_req = 1'b0;
        tick(1);
        checks++;
        if (dut.state_q !== ST_RUN || dut.wait_q !== 8'd0) begin
            errors++;
            $display("FAIL mw_req_drop got st %0d wait %0d want st 0 wait 0",
                     dut.state_q, dut.wait_q);
        end
        idle();
    endtask

    task automatic test_timeout();
        reset_pulse();
        mem_req = 1'b1; mem_ready = 1'b0;
        tick(4);
        checks++;
        if (bus4.MemError !== 1'b0) begin
            errors++; $display("FAIL to4_early got %b want 0", bus4.MemError);
        end
        tick(1);
        checks++;
        if (bus4.MemError !== 1'b1 || en4 !== 5'b00000) begin
            errors++;
            $display("FAIL to4_set got err %b en %b want err 1 en 00000",
                     bus4.MemError, en4);
        end
        checks++;
        if (bus4.StallCount !== 4'd5) begin
            errors++; $display("FAIL to4_count got %0d want 5", bus4.StallCount);
        end
        mem_ready = 1'b1; ex_br = 1'b1;
        #1;
        checks++;
        if (en4 !== 5'b00000 || fl4 !== 2'b00) begin
            errors++;
            $display("FAIL to4_frozen got en %b fl %b want en 00000 fl 00", en4, fl4);
        end
        tick(1);
        checks++;
        if (bus4.MemError !== 1'b1 || bus4.StallCount !== 4'd6) begin
            errors++;
            $display("FAIL to4_sticky got err %b cnt %0d want err 1 cnt 6",
                     bus4.MemError, bus4.StallCount);
        end
        tick(12);
        checks++;
        if (bus4.StallCount !== 4'd15) begin
            errors++; $display("FAIL to4_sat got %0d want 15", bus4.StallCount);
        end
        tick(1);
        checks++;
        if (bus4.StallCount !== 4'd15) begin
            errors++; $display("FAIL to4_nowrap got %0d want 15", bus4.StallCount);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus4.MemError !== 1'b0 || dut4.state_q !== ST_RUN || bus4.StallCount !== 4'd0) begin
            errors++;
            $display("FAIL to4_reset got err %b st %0d cnt %0d want err 0 st 0 cnt 0",
                     bus4.MemError, dut4.state_q, bus4.StallCount);
        end
        idle();
        tick(1);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset_mid_wait();
        mem_req = 1'b1; mem_ready = 1'b0;
        tick(2);
        checks++;
        if (dut.state_q !== ST_MEM_WAIT || dut.wait_q !== 8'd2) begin
            errors++;
            $display("FAIL rmw_pre got st %0d wait %0d want st 1 wait 2",
                     dut.state_q, dut.wait_q);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== ST_RUN || dut.wait_q !== 8'd0 || bus.StallCount !== 16'd0
            || en !== 5'b00000) begin
            errors++;
            $display("FAIL rmw_async got st %0d wait %0d cnt %0d en %b want 0 0 0 00000",
                     dut.state_q, dut.wait_q, bus.StallCount, en);
        end
        #2;
        reset = 1'b1;
        tick(1);
        checks++;
        if (dut.state_q !== ST_MEM_WAIT || dut.wait_q !== 8'd1 || bus.StallCount !== 16'd1) begin
            errors++;
            $display("FAIL rmw_first_edge got st %0d wait %0d cnt %0d want st 1 wait 1 cnt 1",
                     dut.state_q, dut.wait_q, bus.StallCount);
        end
        idle();
        tick(1);
    endtask

    task automatic test_default_timeout();
        reset_pulse();
        mem_req = 1'b1; mem_ready = 1'b0;
        tick(255);
        checks++;
        if (bus.MemError !== 1'b0 || dut.wait_q !== 8'd255) begin
            errors++;
            $display("FAIL to255_early got err %b wait %0d want err 0 wait 255",
                     bus.MemError, dut.wait_q);
        end
        tick(1);
        checks++;
        if (bus.MemError !== 1'b1 || dut.state_q !== ST_ERROR || bus.StallCount !== 16'd256) begin
            errors++;
            $display("FAIL to255_set got err %b st %0d cnt %0d want err 1 st 2 cnt 256",
                     bus.MemError, dut.state_q, bus.StallCount);
        end
        idle();
        reset_pulse();
        checks++;
        if (bus.MemError !== 1'b0 || en !== 5'b11111) begin
            errors++;
            $display("FAIL to255_recover got err %b en %b want err 0 en 11111",
                     bus.MemError, en);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_default_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
